// File: rtl/axi_dma_pkg.sv
// ============================================================================
// Module : axi_dma_pkg
// Brief  : Shared AXI constants, read FSM state type and helper function.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam int         RESP_SLVERR_BIT = 1;
    localparam int         BOUNDARY_4K     = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } rd_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_calc.sv
// ============================================================================
// Module : axi_burst_calc
// Brief  : Combinational burst length = min(beats left, max burst, 4 KB room).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_calc
    import axi_dma_pkg::*;
#(
    parameter int BEATS_WIDTH   = 32,
    parameter int BPB_LOG2      = 2,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [11:0]            i_addr_low,
    input  logic [BEATS_WIDTH-1:0] i_beats_rem,
    output logic [8:0]             o_blen
);

    logic [12:0] w_page_room;
    logic [12:0] w_room_beats;
    logic [12:0] w_cap;

    always_comb begin
        // Address is beat aligned, so at least one beat of room always remains.
        w_page_room  = 13'(BOUNDARY_4K) - {1'b0, i_addr_low};
        w_room_beats = w_page_room >> BPB_LOG2;
        w_cap        = (w_room_beats < 13'(MAX_BURST_LEN)) ? w_room_beats : 13'(MAX_BURST_LEN);
        if (i_beats_rem < BEATS_WIDTH'(w_cap)) begin
            o_blen = 9'(i_beats_rem);
        end else begin
            o_blen = 9'(w_cap);
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_burst_read_master.sv
// ============================================================================
// Module : axi_burst_read_master
// Brief  : AXI4 INCR burst read master feeding a FIFO; optional stall counter
//          enabled by macro AXI_RD_PERF_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_read_master
    import axi_dma_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_MAX_BURST_LEN    = 16,
    parameter int C_LEN_WIDTH        = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
    input  logic [C_LEN_WIDTH-1:0]        i_total_len,
    output logic                          o_busy,
    output logic                          o_read_done,
    output logic                          o_error,
    output logic                          o_fifo_push,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_r_data,
    input  logic                          i_fifo_full,
`ifdef AXI_RD_PERF_CNT_EN
    output logic [31:0]                   o_stall_cycles,
`endif
    output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int c_BPB_LOG2 = clog2(C_M_AXI_DATA_WIDTH / 8);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_MASK =
        ~C_M_AXI_ADDR_WIDTH'((1 << c_BPB_LOG2) - 1);

    rd_state_t                   r_state;
    rd_state_t                   w_next_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_LEN_WIDTH-1:0]      r_beats_rem;
    logic [8:0]                  r_beat_cnt;
    logic                        r_error;
    logic [8:0]                  w_blen;
    logic                        w_beat;
    logic                        w_last_beat;
    logic                        w_resp_err;
    logic [C_LEN_WIDTH-1:0]      w_beats_after;

    axi_burst_calc #(
        .BEATS_WIDTH   (C_LEN_WIDTH),
        .BPB_LOG2      (c_BPB_LOG2),
        .MAX_BURST_LEN (C_MAX_BURST_LEN)
    ) u_calc (
        .i_addr_low  (r_addr[11:0]),
        .i_beats_rem (r_beats_rem),
        .o_blen      (w_blen)
    );

    assign w_beat        = m_axi_rvalid && m_axi_rready;
    assign w_last_beat   = w_beat && (r_beat_cnt == (w_blen - 9'd1));
    assign w_resp_err    = |(m_axi_rresp & (2'b01 << RESP_SLVERR_BIT));
    assign w_beats_after = r_beats_rem - C_LEN_WIDTH'(w_blen);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_beats_rem <= '0;
            r_beat_cnt  <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr      <= i_src_addr & c_ADDR_MASK;
                        r_beats_rem <= i_total_len >> c_BPB_LOG2;
                        r_beat_cnt  <= '0;
                        r_error     <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        // Protocol faults are flagged but the burst still completes.
                        if (w_resp_err || (m_axi_rlast != w_last_beat)) r_error <= 1'b1;
                        if (w_last_beat) begin
                            r_addr      <= r_addr + (C_M_AXI_ADDR_WIDTH'(w_blen) << c_BPB_LOG2);
                            r_beats_rem <= w_beats_after;
                            r_beat_cnt  <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ((i_total_len >> c_BPB_LOG2) == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: if (m_axi_arready) w_next_state = ST_DATA;
            ST_DATA: begin
                if (w_last_beat) w_next_state = (w_beats_after == '0) ? ST_DONE : ST_ADDR;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign m_axi_arid    = '0;
    assign m_axi_arvalid = (r_state == ST_ADDR);
    assign m_axi_araddr  = m_axi_arvalid ? r_addr : '0;
    assign m_axi_arlen   = m_axi_arvalid ? 8'(w_blen - 9'd1) : 8'd0;
    assign m_axi_arsize  = 3'(c_BPB_LOG2);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_rready  = (r_state == ST_DATA) && !i_fifo_full;
    assign o_fifo_push   = w_beat;
    assign o_r_data      = m_axi_rdata;
    assign o_busy        = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign o_read_done   = (r_state == ST_DONE);
    assign o_error       = r_error;

`ifdef AXI_RD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic        w_stall;

    assign w_stall = ((r_state == ST_DATA) && m_axi_rvalid && i_fifo_full) ||
                     ((r_state == ST_ADDR) && !m_axi_arready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire
